turn_signal_input_ctrl: RTL

- Upstream stage of the tail-light sequencer. Its outputs drive that sequencer's left/right inputs directly.
- Conditions the raw dashboard lever and hazard switches:
  - 2-FF synchronizer
  - counter debouncer
  - rising-edge detect
- Runs a latching turn/hazard state machine with auto-cancel timeout.
- Emits clean level requests: left, right, both for hazard.

---
 rtl/turn_signal_pkg.sv | 14 +
 rtl/input_debouncer.sv | 58 +++++
 rtl/turn_signal_input_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/turn_signal_pkg.sv
// Shared state encoding and default timing constants for the turn-signal input stage.
package turn_signal_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LEFT   = 2'd1;
  localparam logic [1:0] ST_RIGHT  = 2'd2;
  localparam logic [1:0] ST_HAZARD = 2'd3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 5000000;

endpackage

// File: rtl/input_debouncer.sv
// Synchronizes, debounces and edge-detects one raw switch contact.
module input_debouncer
  import turn_signal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          stable;
  logic          stable_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw_in;
      sync_2 <= sync_1;
    end
  end

  // The stable level only flips after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_2 == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt    <= '0;
      stable <= sync_2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
    end
  end

  assign level = stable;
  assign press = stable & ~stable_d;

endmodule

// File: rtl/turn_signal_input_ctrl.sv
// Latching turn/hazard request FSM with auto-cancel timer, fed by three debounced switches.
module turn_signal_input_ctrl
  import turn_signal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_left,
  input  logic sw_right,
  input  logic sw_hazard,
  output logic left,
  output logic right,
  output logic hazard_on
);

  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  logic   l_level, r_level, hz_level;
  logic   l_press, r_press, hz_press;
  logic   unused_levels;
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic   timeout;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk(clk), .reset(reset), .raw_in(sw_left), .level(l_level), .press(l_press)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk(clk), .reset(reset), .raw_in(sw_right), .level(r_level), .press(r_press)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_hazard (
    .clk(clk), .reset(reset), .raw_in(sw_hazard), .level(hz_level), .press(hz_press)
  );

  assign unused_levels = l_level ^ r_level ^ hz_level;

  assign timeout = (timer == TW'(TIMEOUT_CYCLES - 1));

  // Presses are checked before timeout so a press in the expiry cycle wins.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (hz_press || (l_press && r_press)) state_nx = ST_HAZARD;
        else if (l_press)                     state_nx = ST_LEFT;
        else if (r_press)                     state_nx = ST_RIGHT;
      end
      ST_LEFT: begin
        if (hz_press || (l_press && r_press)) state_nx = ST_HAZARD;
        else if (l_press)                     state_nx = ST_IDLE;
        else if (r_press)                     state_nx = ST_RIGHT;
        else if (timeout)                     state_nx = ST_IDLE;
      end
      ST_RIGHT: begin
        if (hz_press || (l_press && r_press)) state_nx = ST_HAZARD;
        else if (r_press)                     state_nx = ST_IDLE;
        else if (l_press)                     state_nx = ST_LEFT;
        else if (timeout)                     state_nx = ST_IDLE;
      end
      default: begin
        if (hz_press) state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if ((state_nx != state) || (state == ST_IDLE) || (state == ST_HAZARD)) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      left      <= 1'b0;
      right     <= 1'b0;
      hazard_on <= 1'b0;
    end else begin
      left      <= (state_nx == ST_LEFT)  || (state_nx == ST_HAZARD);
      right     <= (state_nx == ST_RIGHT) || (state_nx == ST_HAZARD);
      hazard_on <= (state_nx == ST_HAZARD);
    end
  end

endmodule
